branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Successor to the single-cycle branch decision logic, for the pipelined RISC-V core.
- The compare is done internally on full XLEN operands, so the block no longer consumes ALU zero/less flags.
- Adds a PC-indexed bimodal predictor: a table of 2-bit saturating counters read in IF and trained at EX resolution.
- Raises a registered flush/redirect on mispredict and keeps saturating branch and mispredict statistics counters.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_ENTRIES, 64, number of 2-bit counters; must be a power of 2, minimum 2.
- IDX_LSB, 2, lowest PC bit used for the table index. Index = pc[IDX_LSB +: log2(BHT_ENTRIES)].
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  XLEN  fetch PC to predict.
- if_pred_taken  out  1  combinational prediction, equal to the MSB of the indexed counter.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_funct3  in  3  branch funct3.
- ex_rs1  in  XLEN  first operand.
- ex_rs2  in  XLEN  second operand.
- ex_pc  in  XLEN  PC of the EX branch.
- ex_target  in  XLEN  taken target (pc + imm), computed upstream.
- ex_pred_taken  in  1  prediction carried down the pipe with this branch.
- ex_taken  out  1  combinational resolved outcome.
- flush  out  1  registered; mispredict detected in the previous cycle.
- redirect_pc  out  XLEN  registered correct next PC; valid when flush=1.
- br_illegal  out  1  registered; previous-cycle branch had an illegal funct3.
- branch_cnt  out  CNT_W  resolved-branch count.
- mispred_cnt  out  CNT_W  mispredict count.

Behaviour:
- Reset (async, rst_n=0):
  - every BHT counter = 2'b01 (weakly not-taken);
  - flush = 0, redirect_pc = 0, br_illegal = 0;
  - branch_cnt = 0, mispred_cnt = 0.
  - Reset asserted mid-operation clears all of the above immediately, independent of clk.
- Resolve condition: res = ex_valid & ex_branch.
- ex_taken is combinational, and 0 when res = 0:
  - 000 beq: rs1 == rs2
  - 001 bne: rs1 != rs2
  - 100 blt: signed rs1 < rs2
  - 101 bge: signed rs1 >= rs2
  - 110 bltu: unsigned rs1 < rs2
  - 111 bgeu: unsigned rs1 >= rs2
  - 010, 011: illegal; ex_taken = 0.
- Legal branch: res = 1 and funct3 not 010/011.
- Mispredict: legal branch and ex_taken != ex_pred_taken.
- On each clk edge, with a legal branch:
  - counter at ex_pc index increments if taken, decrements if not;
  - counter saturates at 2'b11 and 2'b00;
  - branch_cnt += 1, saturating at all-ones.
- On each clk edge, with a mispredict:
  - mispred_cnt += 1, saturating at all-ones.
- Registered outputs, latency 1 cycle after EX:
  - flush <= mispredict;
  - redirect_pc <= ex_taken ? ex_target : ex_pc + 4, computed modulo 2^XLEN;
  - when no mispredict, redirect_pc holds its previous value.
- Illegal funct3 with res = 1:
  - br_illegal <= 1 for one cycle;
  - no BHT update, no counter change, flush <= 0.
- res = 0: nothing updates; flush <= 0, br_illegal <= 0.
- IF read and EX write to the same index in the same cycle: if_pred_taken reflects the pre-update (old) value. No bypass.
- if_pc and ex_pc aliasing to the same index is accepted; no tags are kept.
- flush is a single-cycle pulse per mispredict. Back-to-back mispredicts produce back-to-back flush=1, each cycle with its own redirect_pc.
- Statistics counters never wrap.

Test Plan:
- Reset, then sweep if_pc over all BHT_ENTRIES indices -> if_pred_taken = 0 everywhere; flush = 0, branch_cnt = 0, mispred_cnt = 0.
- Signed vs unsigned compare: rs1=0xFFFFFFFF, rs2=0x00000001:
  - blt -> ex_taken = 1; bltu -> 0;
  - bge -> 0; bgeu -> 1;
  - beq with rs1 = rs2 = 0x5 -> 1; bne -> 0.
- Mispredict and redirect:
  - bne taken, ex_pred_taken=0, ex_pc=0x100, ex_target=0x180 -> next cycle flush=1, redirect_pc=0x180, mispred_cnt=1.
  - beq not-taken, pred=1, pc=0x200 -> flush=1, redirect_pc=0x204.
- Saturation and hysteresis at ex_pc=0x40:
  - 3 taken resolves -> counter 11, if_pc=0x40 predicts 1;
  - 1 not-taken -> still predicts 1;
  - 2 more not-taken -> predicts 0.
- Same-index collision: if_pc = ex_pc = 0x40, counter 01, taken resolve -> if_pred_taken = 0 that cycle, 1 the next.
- Illegal funct3 = 010 with ex_valid = 1, ex_branch = 1 -> br_illegal pulses for one cycle; BHT, branch_cnt and flush unchanged.
- rst_n dropped asynchronously between clk edges while flush = 1 -> flush, counters and BHT clear immediately.

Source files
------------

// File: rtl/branch_predict_unit.sv
// branch_predict_unit
// EX-stage branch resolution with a PC-indexed bimodal predictor.
// A table of 2-bit saturating counters is read combinationally in IF and
// trained when a legal conditional branch resolves in EX. A mispredict
// raises a one-cycle registered flush with the correct redirect PC.
// Saturating statistics count resolved branches and mispredicts.
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_LSB     = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  output logic             ex_taken,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             br_illegal,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = (BHT_ENTRIES > 2) ? $clog2(BHT_ENTRIES) : 1;

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             res;
  logic             illegal_f3;
  logic             cmp_taken;
  logic             legal_br;
  logic             mispredict;
  logic [XLEN-1:0]  next_pc;
  logic             unused_pc_bits;

  // Only a slice of each PC forms the table index; the remaining bits are
  // deliberately ignored because the table keeps no tags.
  assign if_idx         = if_pc[IDX_LSB +: IDX_W];
  assign ex_idx         = ex_pc[IDX_LSB +: IDX_W];
  assign unused_pc_bits = ^if_pc;

  // IF prediction reads the stored counter directly, so a same-cycle EX
  // update to the same entry is only seen on the following cycle.
  assign if_pred_taken = bht[if_idx][1];

  // Full-width compare selected by funct3; 010/011 are flagged illegal.
  always_comb begin
    cmp_taken  = 1'b0;
    illegal_f3 = 1'b0;
    case (ex_funct3)
      3'b000:  cmp_taken = (ex_rs1 == ex_rs2);
      3'b001:  cmp_taken = (ex_rs1 != ex_rs2);
      3'b100:  cmp_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  cmp_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  cmp_taken = (ex_rs1 <  ex_rs2);
      3'b111:  cmp_taken = (ex_rs1 >= ex_rs2);
      default: illegal_f3 = 1'b1;
    endcase
  end

  assign res        = ex_valid & ex_branch;
  assign legal_br   = res & ~illegal_f3;
  assign ex_taken   = legal_br & cmp_taken;
  assign mispredict = legal_br & (ex_taken != ex_pred_taken);
  assign next_pc    = ex_taken ? ex_target : (ex_pc + XLEN'(4));

  // Train the counter at the EX index, saturating at both ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (legal_br) begin
      if (ex_taken) begin
        if (bht[ex_idx] != 2'b11) begin
          bht[ex_idx] <= bht[ex_idx] + 2'd1;
        end
      end else begin
        if (bht[ex_idx] != 2'b00) begin
          bht[ex_idx] <= bht[ex_idx] - 2'd1;
        end
      end
    end
  end

  // Register the flush pulse and illegal flag; redirect only loads on a mispredict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush       <= 1'b0;
      br_illegal  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush      <= mispredict;
      br_illegal <= res & illegal_f3;
      if (mispredict) begin
        redirect_pc <= next_pc;
      end
    end
  end

  // Saturating statistics; they stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (legal_br && (branch_cnt != '1)) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (mispredict && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit
// Scoreboard bench: the driver pushes expected responses computed from a
// behavioural predictor model, and a monitor pops and compares them.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic        ex_branch;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        ex_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        br_illegal;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  branch_predict_unit #(
    .XLEN(32), .BHT_ENTRIES(64), .IDX_LSB(2), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken),
    .flush(flush), .redirect_pc(redirect_pc), .br_illegal(br_illegal),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          taken;
    bit          pred;
    bit          flush;
    logic [31:0] redirect;
    bit          illegal;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Behavioural model state: counters as plain integers 0..3
  int          bht_m [64];
  bit          flush_m;
  bit          ill_m;
  logic [31:0] redir_m;
  logic [31:0] bcnt_m;
  logic [31:0] mcnt_m;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit model_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 64; i++) bht_m[i] = 1;
    flush_m = 0;
    ill_m   = 0;
    redir_m = 0;
    bcnt_m  = 0;
    mcnt_m  = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus: drive inputs, push the expected response, then
  // advance the model to what the next clock edge should produce.
  task automatic applyStimulus(input bit v, input bit br, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input logic [31:0] tgt,
                               input bit pred, input logic [31:0] ipc);
    exp_t e;
    bit res, legal, tk, mis;
    @(posedge clk);
    #1;
    ex_valid = v; ex_branch = br; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pred; if_pc = ipc;

    res   = v && br;
    legal = res && (f3 != 3'd2) && (f3 != 3'd3);
    tk    = legal && model_taken(f3, a, b);
    mis   = legal && (tk != pred);

    e.taken    = tk;
    e.pred     = (bht_m[idx_of(ipc)] >= 2);
    e.flush    = flush_m;
    e.redirect = redir_m;
    e.illegal  = ill_m;
    e.bcnt     = bcnt_m;
    e.mcnt     = mcnt_m;
    exp_q.push_back(e);

    if (legal) begin
      if (tk && bht_m[idx_of(pc)] < 3) bht_m[idx_of(pc)]++;
      if (!tk && bht_m[idx_of(pc)] > 0) bht_m[idx_of(pc)]--;
      if (bcnt_m != 32'hFFFF_FFFF) bcnt_m++;
    end
    if (mis) begin
      if (mcnt_m != 32'hFFFF_FFFF) mcnt_m++;
      redir_m = tk ? tgt : pc + 32'd4;
    end
    flush_m = mis;
    ill_m   = res && !legal;
  endtask

  task automatic idle(input logic [31:0] ipc);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 0, 0, ipc);
  endtask

  // Monitor: each falling edge, compare the DUT against the oldest expectation
  always begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("ex_taken",      32'(ex_taken),      32'(e.taken));
      checkOutput("if_pred_taken", 32'(if_pred_taken), 32'(e.pred));
      checkOutput("flush",         32'(flush),         32'(e.flush));
      checkOutput("redirect_pc",   redirect_pc,        e.redirect);
      checkOutput("br_illegal",    32'(br_illegal),    32'(e.illegal));
      checkOutput("branch_cnt",    branch_cnt,         e.bcnt);
      checkOutput("mispred_cnt",   mispred_cnt,        e.mcnt);
    end
  end

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_branch = 0; ex_funct3 = 0; ex_rs1 = 0; ex_rs2 = 0;
    ex_pc = 0; ex_target = 0; ex_pred_taken = 0; if_pc = 0;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep every table index after reset
    for (int i = 0; i < 64; i++) idle(32'(i) << 2);

    // Signed versus unsigned compares
    applyStimulus(1, 1, 3'd4, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h340, 1, 32'h0);
    applyStimulus(1, 1, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h304, 32'h340, 0, 32'h0);
    applyStimulus(1, 1, 3'd5, 32'hFFFF_FFFF, 32'h1, 32'h308, 32'h340, 0, 32'h0);
    applyStimulus(1, 1, 3'd7, 32'hFFFF_FFFF, 32'h1, 32'h30C, 32'h340, 1, 32'h0);
    applyStimulus(1, 1, 3'd0, 32'h5, 32'h5, 32'h310, 32'h340, 1, 32'h0);
    applyStimulus(1, 1, 3'd1, 32'h5, 32'h5, 32'h314, 32'h340, 0, 32'h0);

    // Mispredicts with both redirect sources
    applyStimulus(1, 1, 3'd1, 32'h1, 32'h2, 32'h100, 32'h180, 0, 32'h0);
    applyStimulus(1, 1, 3'd0, 32'h1, 32'h2, 32'h200, 32'h280, 1, 32'h0);
    idle(32'h0);

    // Saturation and hysteresis at pc 0x40
    repeat (3) applyStimulus(1, 1, 3'd0, 32'h7, 32'h7, 32'h40, 32'h80, 0, 32'h40);
    idle(32'h40);
    applyStimulus(1, 1, 3'd1, 32'h7, 32'h7, 32'h40, 32'h80, 1, 32'h40);
    idle(32'h40);
    repeat (2) applyStimulus(1, 1, 3'd1, 32'h7, 32'h7, 32'h40, 32'h80, 1, 32'h40);
    idle(32'h40);

    // Step back to 01, then a same-index collision
    applyStimulus(1, 1, 3'd0, 32'h0, 32'h0, 32'h40, 32'h80, 0, 32'h40);
    applyStimulus(1, 1, 3'd0, 32'h0, 32'h0, 32'h40, 32'h80, 0, 32'h40);
    idle(32'h40);

    // Illegal funct3 codes
    applyStimulus(1, 1, 3'd2, 32'h3, 32'h3, 32'h44, 32'h90, 1, 32'h44);
    applyStimulus(1, 1, 3'd3, 32'h3, 32'h4, 32'h44, 32'h90, 0, 32'h44);
    idle(32'h44);
    idle(32'h44);

    // Randomised traffic over a handful of indices
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b, pc, ipc;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      pc  = 32'($urandom_range(0, 15)) << 2;
      ipc = 32'($urandom_range(0, 15)) << 2;
      applyStimulus(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0),
                    3'($urandom_range(0, 7)), a, b, pc, 32'($urandom) & ~32'h3,
                    1'($urandom_range(0, 1)), ipc);
    end

    // Asynchronous reset while flush is high
    applyStimulus(1, 1, 3'd1, 32'h1, 32'h2, 32'h40, 32'hA0, 0, 32'h40);
    applyStimulus(1, 1, 3'd1, 32'h1, 32'h2, 32'h40, 32'hA0, 0, 32'h40);
    idle(32'h40);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async flush",       32'(flush),         32'd0);
    checkOutput("async redirect_pc", redirect_pc,        32'd0);
    checkOutput("async br_illegal",  32'(br_illegal),    32'd0);
    checkOutput("async branch_cnt",  branch_cnt,         32'd0);
    checkOutput("async mispred_cnt", mispred_cnt,        32'd0);
    checkOutput("async bht",         32'(if_pred_taken), 32'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) idle(32'(i) << 2);
    applyStimulus(1, 1, 3'd1, 32'h1, 32'h2, 32'h40, 32'hA0, 0, 32'h40);
    idle(32'h40);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
